if_pc_btb_unit: RTL

IF-stage program-counter generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction predictors, for the RV32I 5-stage pipeline. It sits upstream of the hazard unit. It consumes pc_en and modify_pc_ex, and takes redirect and update information from EX branch resolution. It drives the fetch PC plus prediction metadata, which travel down the pipe to EX. It also keeps branch and mispredict statistics counters.

---
 rtl/if_pc_btb_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/if_pc_btb_unit.sv
// IF-stage fetch PC generator with a 2^INDEX_BITS-entry direct-mapped BTB and 2-bit counters.
// Latency: next PC is registered (1 cycle); no backpressure beyond pc_en stall, and EX redirects override stalls.
module if_pc_btb_unit #(
  parameter int          INDEX_BITS = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  logic        modify_pc_ex,
  input  logic [31:0] ex_redirect_pc,
  input  logic        ex_update_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_mispredict,
  output logic [31:0] pc_if,
  output logic        if_valid,
  output logic        predict_taken_if,
  output logic [31:0] predict_target_if,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;

  typedef struct packed {
    logic                vld;
    logic [TAG_BITS-1:0] tag;
    logic [31:0]         target;
    logic [1:0]          ctr;
  } btb_entry_t;

  btb_entry_t btb [ENTRIES];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [TAG_BITS-1:0]   rd_tag;
  btb_entry_t            rd_entry;
  logic                  rd_hit;

  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0]   wr_tag;
  btb_entry_t            wr_old;
  btb_entry_t            wr_new;
  logic                  wr_hit;
  logic                  wr_en;

  logic [1:0]            unused_ex_pc_lo;
  logic [31:0]           pc_next;

  assign unused_ex_pc_lo = ex_pc[1:0];

  // Lookup reads the array as it stands this cycle, so a same-index update lands after it.
  assign rd_idx            = pc_if[INDEX_BITS+1:2];
  assign rd_tag            = pc_if[31:INDEX_BITS+2];
  assign rd_entry          = btb[rd_idx];
  assign rd_hit            = rd_entry.vld && (rd_entry.tag == rd_tag);
  assign predict_taken_if  = rd_hit && rd_entry.ctr[1];
  assign predict_target_if = rd_hit ? rd_entry.target : 32'h0;

  assign wr_idx = ex_pc[INDEX_BITS+1:2];
  assign wr_tag = ex_pc[31:INDEX_BITS+2];
  assign wr_old = btb[wr_idx];
  assign wr_hit = wr_old.vld && (wr_old.tag == wr_tag);
  assign wr_en  = ex_update_valid && (wr_hit || ex_taken);

  always_comb begin
    wr_new = wr_old;
    if (wr_hit) begin
      if (ex_taken) begin
        wr_new.target = ex_target;
        if (wr_old.ctr != 2'b11) wr_new.ctr = wr_old.ctr + 2'd1;
      end else if (wr_old.ctr != 2'b00) begin
        wr_new.ctr = wr_old.ctr - 2'd1;
      end
    end else begin
      wr_new.vld    = 1'b1;
      wr_new.tag    = wr_tag;
      wr_new.target = ex_target;
      wr_new.ctr    = 2'b10;
    end
  end

  always_comb begin
    pc_next = pc_if + 32'd4;
    if (modify_pc_ex)          pc_next = ex_redirect_pc;
    else if (!pc_en)           pc_next = pc_if;
    else if (predict_taken_if) pc_next = predict_target_if;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_if            <= RESET_PC;
      if_valid         <= 1'b0;
      branch_count     <= 32'h0;
      mispredict_count <= 32'h0;
    end else begin
      pc_if    <= pc_next;
      if_valid <= 1'b1;
      if (ex_update_valid) begin
        branch_count <= branch_count + 32'd1;
        if (ex_mispredict) mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i] <= '{vld: 1'b0, tag: '0, target: 32'h0, ctr: 2'b01};
      end
    end else if (wr_en) begin
      btb[wr_idx] <= wr_new;
    end
  end

endmodule
